// File: rtl/tft_timing_ctrl_if.sv
// ---------------------------------------------------------------------------
// tft_timing_ctrl_if
// Bundles the signals between the TFT timing controller, its upstream pixel
// source and the panel pins.
//   pix_x / pix_y : next-pixel coordinate request (3FF when idle)
//   pix_data      : RGB565 pixel returned by the source one cycle later
//   rgb_tft       : panel pixel data
//   hsync / vsync : active-high sync pulses
//   tft_clk       : pixel clock forwarded to the panel
//   tft_de        : data enable
//   tft_bl        : backlight enable
// master = timing controller, slave = pixel source / panel side.
// ---------------------------------------------------------------------------
interface tft_timing_ctrl_if;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [15:0] pix_data;
    logic [15:0] rgb_tft;
    logic        hsync;
    logic        vsync;
    logic        tft_clk;
    logic        tft_de;
    logic        tft_bl;

    modport master (
        input  pix_data,
        output pix_x, pix_y, rgb_tft, hsync, vsync, tft_clk, tft_de, tft_bl
    );

    modport slave (
        output pix_data,
        input  pix_x, pix_y, rgb_tft, hsync, vsync, tft_clk, tft_de, tft_bl
    );
endinterface

// File: rtl/tft_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tft_timing_ctrl
// Free-running horizontal/vertical timing generator for a 480x272 RGB565
// panel at 9 MHz. Produces HSYNC, VSYNC, DE and backlight enable, forwards
// the pixel clock, and requests the next pixel coordinate one cycle before
// it is displayed so a registered pixel source can respond in time.
// Ports:
//   tft_clk_9m : pixel clock (only clock)
//   sys_rst    : asynchronous active-high reset
//   bus        : master side of tft_timing_ctrl_if (pixel request + panel pins)
// ---------------------------------------------------------------------------
module tft_timing_ctrl #(
    parameter logic [9:0] H_SYNC  = 10'd41,
    parameter logic [9:0] H_BACK  = 10'd2,
    parameter logic [9:0] H_VALID = 10'd480,
    parameter logic [9:0] H_FRONT = 10'd2,
    parameter logic [9:0] V_SYNC  = 10'd10,
    parameter logic [9:0] V_BACK  = 10'd2,
    parameter logic [9:0] V_VALID = 10'd272,
    parameter logic [9:0] V_FRONT = 10'd2
) (
    input  logic                tft_clk_9m,
    input  logic                sys_rst,
    tft_timing_ctrl_if.master   bus
);

    localparam logic [9:0] H_TOTAL    = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam logic [9:0] V_TOTAL    = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam logic [9:0] H_DE_START = H_SYNC + H_BACK;
    localparam logic [9:0] H_DE_END   = H_DE_START + H_VALID - 10'd1;
    // The request window leads the display window by one clock.
    localparam logic [9:0] H_RQ_START = H_DE_START - 10'd1;
    localparam logic [9:0] H_RQ_END   = H_DE_END - 10'd1;
    localparam logic [9:0] V_DE_START = V_SYNC + V_BACK;
    localparam logic [9:0] V_DE_END   = V_DE_START + V_VALID - 10'd1;

    logic [9:0]  cnt_h_q, cnt_h_d;
    logic [9:0]  cnt_v_q, cnt_v_d;
    logic        h_valid_s;
    logic        v_valid_s;
    logic        pix_req_s;
    logic        de_s;
    logic        hsync_s;
    logic        vsync_s;
    logic [15:0] rgb_s;
    logic [9:0]  pix_x_s;
    logic [9:0]  pix_y_s;

    // Next-state for the line and frame counters.
    always_comb begin
        cnt_h_d = cnt_h_q;
        cnt_v_d = cnt_v_q;
        if (cnt_h_q == H_TOTAL - 10'd1) begin
            cnt_h_d = 10'd0;
            // The vertical counter wraps on the same edge as the last line ends.
            if (cnt_v_q == V_TOTAL - 10'd1) begin
                cnt_v_d = 10'd0;
            end else begin
                cnt_v_d = cnt_v_q + 10'd1;
            end
        end else begin
            cnt_h_d = cnt_h_q + 10'd1;
        end
    end

    // Counter registers with asynchronous clear.
    always_ff @(posedge tft_clk_9m or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_h_q <= 10'd0;
            cnt_v_q <= 10'd0;
        end else begin
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
        end
    end

    // Output decode of the counters; sync pulses are forced low in reset
    // because the cleared counters would otherwise decode as active sync.
    always_comb begin
        h_valid_s = 1'b0;
        v_valid_s = 1'b0;
        pix_req_s = 1'b0;
        de_s      = 1'b0;
        hsync_s   = 1'b0;
        vsync_s   = 1'b0;
        rgb_s     = 16'h0000;
        pix_x_s   = 10'h3FF;
        pix_y_s   = 10'h3FF;
        if (sys_rst) begin
            de_s = 1'b0;
        end else begin
            h_valid_s = (cnt_h_q >= H_DE_START) && (cnt_h_q <= H_DE_END);
            v_valid_s = (cnt_v_q >= V_DE_START) && (cnt_v_q <= V_DE_END);
            pix_req_s = v_valid_s && (cnt_h_q >= H_RQ_START) && (cnt_h_q <= H_RQ_END);
            de_s      = h_valid_s && v_valid_s;
            hsync_s   = (cnt_h_q < H_SYNC);
            vsync_s   = (cnt_v_q < V_SYNC);
            if (de_s) begin
                rgb_s = bus.pix_data;
            end else begin
                rgb_s = 16'h0000;
            end
            if (pix_req_s) begin
                pix_x_s = cnt_h_q - H_RQ_START;
                pix_y_s = cnt_v_q - V_DE_START;
            end else begin
                pix_x_s = 10'h3FF;
                pix_y_s = 10'h3FF;
            end
        end
    end

    assign bus.hsync   = hsync_s;
    assign bus.vsync   = vsync_s;
    assign bus.tft_de  = de_s;
    assign bus.rgb_tft = rgb_s;
    assign bus.pix_x   = pix_x_s;
    assign bus.pix_y   = pix_y_s;
    assign bus.tft_clk = tft_clk_9m;
    assign bus.tft_bl  = ~sys_rst;

endmodule

// File: tb/tb_tft_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tft_timing_ctrl
// Self-checking bench for tft_timing_ctrl. A bench-side cycle counter, reset
// to 0 at each reset release, gives the expected counter position
// (line = cyc / 525, column = cyc % 525).
// ---------------------------------------------------------------------------
module tb_tft_timing_ctrl;

    localparam int HT = 525;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [15:0] tb_data = 16'h0000;
    logic [15:0] up_data = 16'h0000;
    logic        up_en = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    tft_timing_ctrl_if ifc ();

    tft_timing_ctrl dut (
        .tft_clk_9m (clk),
        .sys_rst    (sys_rst),
        .bus        (ifc)
    );

    always #55 clk = ~clk;

    // Upstream registered pixel source: registers a coordinate-derived pattern.
    always @(posedge clk) begin
        up_data <= {ifc.pix_y[4:0], ifc.pix_x[5:0], ifc.pix_y[4:0]};
    end

    assign ifc.pix_data = up_en ? up_data : tb_data;

    typedef struct {
        int          line;
        int          h;
        logic [15:0] pdata;
        logic        de;
        logic [15:0] rgb;
        logic [9:0]  px;
        logic [9:0]  py;
        logic        hs;
        logic        vs;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " de"},    {31'd0, ifc.tft_de}, 32'd0);
        chk({tag, " rgb"},   {16'd0, ifc.rgb_tft}, 32'd0);
        chk({tag, " pix_x"}, {22'd0, ifc.pix_x}, 32'h3FF);
        chk({tag, " pix_y"}, {22'd0, ifc.pix_y}, 32'h3FF);
        chk({tag, " bl"},    {31'd0, ifc.tft_bl}, 32'd0);
        chk({tag, " hsync"}, {31'd0, ifc.hsync}, 32'd0);
        chk({tag, " vsync"}, {31'd0, ifc.vsync}, 32'd0);
    endtask

    initial begin
        int hs_high, hs_rise, vs_high, de_high, px_bad, pat_err, de_line14, de_line15;
        logic prev_hs;
        int target, h, v;
        logic exp_de;
        logic [15:0] exp_rgb;
        logic [9:0] xx, yy;

        //               line  h    pdata     de    rgb       px      py      hs    vs
        vecs[0]  = '{10, 200, 16'hFFFF, 1'b0, 16'h0000, 10'h3FF, 10'h3FF, 1'b0, 1'b0};
        vecs[1]  = '{11, 300, 16'hFFFF, 1'b0, 16'h0000, 10'h3FF, 10'h3FF, 1'b0, 1'b0};
        vecs[2]  = '{12,   0, 16'h1234, 1'b0, 16'h0000, 10'h3FF, 10'h3FF, 1'b1, 1'b0};
        vecs[3]  = '{12,  40, 16'h1234, 1'b0, 16'h0000, 10'h3FF, 10'h3FF, 1'b1, 1'b0};
        vecs[4]  = '{12,  41, 16'h1234, 1'b0, 16'h0000, 10'h3FF, 10'h3FF, 1'b0, 1'b0};
        vecs[5]  = '{12,  42, 16'hFFFF, 1'b0, 16'h0000, 10'd0,   10'd0,   1'b0, 1'b0};
        vecs[6]  = '{12,  43, 16'hFFFF, 1'b1, 16'hFFFF, 10'd1,   10'd0,   1'b0, 1'b0};
        vecs[7]  = '{12, 100, 16'hA5A5, 1'b1, 16'hA5A5, 10'd58,  10'd0,   1'b0, 1'b0};
        vecs[8]  = '{12, 521, 16'h5A5A, 1'b1, 16'h5A5A, 10'd479, 10'd0,   1'b0, 1'b0};
        vecs[9]  = '{12, 522, 16'h0F0F, 1'b1, 16'h0F0F, 10'h3FF, 10'h3FF, 1'b0, 1'b0};
        vecs[10] = '{12, 523, 16'hFFFF, 1'b0, 16'h0000, 10'h3FF, 10'h3FF, 1'b0, 1'b0};
        vecs[11] = '{13,   0, 16'hFFFF, 1'b0, 16'h0000, 10'h3FF, 10'h3FF, 1'b1, 1'b0};
        vecs[12] = '{13,  42, 16'h0001, 1'b0, 16'h0000, 10'd0,   10'd1,   1'b0, 1'b0};
        vecs[13] = '{13, 300, 16'h8001, 1'b1, 16'h8001, 10'd258, 10'd1,   1'b0, 1'b0};

        // Reset held for 200 ns with non-zero pixel data offered.
        tb_data = 16'hFFFF;
        #200;
        chk_reset_outputs("in_reset");
        chk("clk_passthru", {31'd0, ifc.tft_clk}, {31'd0, clk});

        @(negedge clk);
        sys_rst = 1'b0;
        cyc = 0;
        #1;
        chk("release bl", {31'd0, ifc.tft_bl}, 32'd1);
        chk("release hsync", {31'd0, ifc.hsync}, 32'd1);
        chk("release vsync", {31'd0, ifc.vsync}, 32'd1);

        // Monitor the blanking lines at the top of the first frame.
        hs_high = 0; hs_rise = -1; vs_high = 0; de_high = 0; px_bad = 0;
        prev_hs = 1'b1;
        while (1) begin
            if (cyc < HT && ifc.hsync) hs_high++;
            if (hs_rise < 0 && ifc.hsync && !prev_hs) hs_rise = cyc;
            prev_hs = ifc.hsync;
            if (ifc.vsync) vs_high++;
            if (ifc.tft_de) de_high++;
            if (ifc.pix_x != 10'h3FF || ifc.pix_y != 10'h3FF) px_bad++;
            if (cyc == 5300) break;
            tick();
        end
        chk("hsync width", hs_high, 32'd41);
        chk("hsync period", hs_rise, 32'd525);
        chk("vsync width", vs_high, 32'd5250);
        chk("blank de", de_high, 32'd0);
        chk("blank pix req", px_bad, 32'd0);

        // Directed vectors around the first active lines.
        for (int i = 0; i < 14; i++) begin
            target = vecs[i].line * HT + vecs[i].h;
            while (cyc < target) tick();
            tb_data = vecs[i].pdata;
            #1;
            chk($sformatf("vec%0d de", i),    {31'd0, ifc.tft_de},  {31'd0, vecs[i].de});
            chk($sformatf("vec%0d rgb", i),   {16'd0, ifc.rgb_tft}, {16'd0, vecs[i].rgb});
            chk($sformatf("vec%0d pix_x", i), {22'd0, ifc.pix_x},   {22'd0, vecs[i].px});
            chk($sformatf("vec%0d pix_y", i), {22'd0, ifc.pix_y},   {22'd0, vecs[i].py});
            chk($sformatf("vec%0d hsync", i), {31'd0, ifc.hsync},   {31'd0, vecs[i].hs});
            chk($sformatf("vec%0d vsync", i), {31'd0, ifc.vsync},   {31'd0, vecs[i].vs});
        end

        // Registered upstream source over lines 14 and 15.
        while (cyc < 14 * HT) tick();
        up_en = 1'b1;
        pat_err = 0; de_line14 = 0; de_line15 = 0;
        while (cyc < 16 * HT) begin
            h = cyc % HT;
            v = cyc / HT;
            exp_de = (h >= 43) && (h <= 522);
            xx = 10'(h - 43);
            yy = 10'(v - 12);
            exp_rgb = exp_de ? {yy[4:0], xx[5:0], yy[4:0]} : 16'h0000;
            if (ifc.tft_de !== exp_de || ifc.rgb_tft !== exp_rgb) begin
                if (pat_err < 4)
                    $display("FAIL pattern: cyc %0d de %0b rgb %h expected de %0b rgb %h",
                             cyc, ifc.tft_de, ifc.rgb_tft, exp_de, exp_rgb);
                pat_err++;
            end
            if (ifc.tft_de && v == 14) de_line14++;
            if (ifc.tft_de && v == 15) de_line15++;
            tick();
        end
        up_en = 1'b0;
        tb_data = 16'hFFFF;
        chk("pattern errors", pat_err, 32'd0);
        chk("de count line14", de_line14, 32'd480);
        chk("de count line15", de_line15, 32'd480);

        // Reset in the middle of an active line.
        while (cyc < 16 * HT + 300) tick();
        #1;
        chk("pre-reset de", {31'd0, ifc.tft_de}, 32'd1);
        sys_rst = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset_hold");
        sys_rst = 1'b0;
        cyc = 0;
        #1;
        chk("restart hsync", {31'd0, ifc.hsync}, 32'd1);
        chk("restart vsync", {31'd0, ifc.vsync}, 32'd1);
        while (!ifc.tft_de && cyc < 7000) tick();
        chk("first de after reset", cyc, 32'(12 * HT + 43));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
